// File: rtl/servo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : servo_pkg                                                    |
// | Description : Shared helpers for the hobby-servo PWM generator: derivation |
// |               of frame and pulse lengths (in clocks) from the frequency    |
// |               and microsecond parameters, plus the default counter type.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package servo_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;

   // Counter type at the default width; the top level derives its own
   // WIDTH-bit counter type from its parameter.
   typedef logic [DEFAULT_WIDTH-1:0] servo_count_t;

   // Frame length in clocks. Evaluated in 64 bits so large clock rates
   // cannot overflow during elaboration.
   function automatic longint unsigned calc_n_clks(
      input longint unsigned clock_freq,
      input longint unsigned pwm_freq
   );
      return clock_freq / pwm_freq;
   endfunction

   // Pulse length in clocks for a width given in microseconds. The product
   // (e.g. 50 MHz x 2000 us) exceeds 32 bits, hence 64-bit arithmetic.
   function automatic longint unsigned calc_pulse_clks(
      input longint unsigned clock_freq,
      input longint unsigned pulse_us
   );
      return (clock_freq * pulse_us) / 64'd1_000_000;
   endfunction

endpackage
`default_nettype wire

// File: rtl/servo_pulse_map.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : servo_pulse_map                                              |
// | Description : Combinational map from an 8-bit duty command to a pulse      |
// |               length in clocks:                                            |
// |                  pulse = MIN_CLKS + floor(d * (MAX_CLKS - MIN_CLKS) / 255) |
// | Ports       : i_duty_cycle  [7:0]        unsigned position command         |
// |               o_pulse_clks  [WIDTH-1:0]  pulse length in clocks            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module servo_pulse_map #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] MIN_CLKS = '0,
   parameter logic [WIDTH-1:0] MAX_CLKS = '0
) (
   input  logic [7:0]       i_duty_cycle,
   output logic [WIDTH-1:0] o_pulse_clks
);

   // Eight extra bits hold d * span (d <= 255) without overflow.
   localparam int                 c_ext_w   = WIDTH + 8;
   localparam logic [c_ext_w-1:0] c_span    = c_ext_w'(MAX_CLKS - MIN_CLKS);
   localparam logic [c_ext_w-1:0] c_min_ext = c_ext_w'(MIN_CLKS);
   localparam logic [c_ext_w-1:0] c_div     = c_ext_w'(255);

   logic [c_ext_w-1:0] w_product;

   assign w_product = c_ext_w'(i_duty_cycle) * c_span;

   // The quotient never exceeds the span, so the sum always fits in WIDTH
   // bits and d = 255 lands exactly on MAX_CLKS.
   assign o_pulse_clks = WIDTH'(c_min_ext + (w_product / c_div));

endmodule
`default_nettype wire

// File: rtl/servo_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : servo_controller                                             |
// | Description : Hobby-servo PWM generator. A free-running frame counter      |
// |               (default 20 ms) drives a registered output that is high for  |
// |               a pulse length mapped linearly from duty_cycle onto          |
// |               MIN_PULSE_US..MAX_PULSE_US. The duty command is sampled only |
// |               at frame boundaries so pulses are never cut or stretched.    |
// | Ports       : clock        rising-edge clock                               |
// |               reset        asynchronous, active-low                        |
// |               enable       run when 1, idle at end-of-frame when 0         |
// |               duty_cycle   [7:0] unsigned position command                 |
// |               servo_pwm    registered PWM output                           |
// |               n_clks       [WIDTH-1:0] frame length in clocks (constant)   |
// |               cycle_time   [WIDTH-1:0] current frame position              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module servo_controller
   import servo_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ   = 50_000_000,
   parameter int unsigned PWM_FREQ     = 50,
   parameter int unsigned MIN_PULSE_US = 1000,
   parameter int unsigned MAX_PULSE_US = 2000,
   parameter int          WIDTH        = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [7:0]       duty_cycle,
   output logic             servo_pwm,
   output logic [WIDTH-1:0] n_clks,
   output logic [WIDTH-1:0] cycle_time
);

   localparam type count_t = logic [WIDTH-1:0];

   localparam longint unsigned c_n_64   = calc_n_clks(64'(CLOCK_FREQ), 64'(PWM_FREQ));
   localparam longint unsigned c_min_64 = calc_pulse_clks(64'(CLOCK_FREQ), 64'(MIN_PULSE_US));
   localparam longint unsigned c_max_64 = calc_pulse_clks(64'(CLOCK_FREQ), 64'(MAX_PULSE_US));

   localparam count_t c_n_clks   = count_t'(c_n_64);
   localparam count_t c_last     = count_t'(c_n_64 - 64'd1);
   localparam count_t c_min_clks = count_t'(c_min_64);
   localparam count_t c_max_clks = count_t'(c_max_64);
   localparam count_t c_one      = count_t'(1);

   // Reject parameter sets that cannot produce a sensible frame.
   if ((c_min_64 < 64'd1) || (c_min_64 > c_max_64) || (c_max_64 >= c_n_64) ||
       ((WIDTH < 64) && (c_n_64 >= (64'd1 << WIDTH)))) begin : g_bad_params
      $error("servo_controller: need 1 <= MIN_CLKS <= MAX_CLKS < N_CLKS < 2**WIDTH");
   end

   count_t r_cycle_time;
   count_t r_pulse_q;
   logic   r_servo_pwm;

   count_t w_next;
   count_t w_pulse_new;
   count_t w_frame_pulse;
   logic   w_wrap;

   servo_pulse_map #(
      .WIDTH    (WIDTH),
      .MIN_CLKS (c_min_clks),
      .MAX_CLKS (c_max_clks)
   ) u_pulse_map (
      .i_duty_cycle (duty_cycle),
      .o_pulse_clks (w_pulse_new)
   );

   // N_CLKS > 1 is guaranteed, so the counter's next value is zero exactly
   // when it currently sits on the last clock of the frame.
   assign w_wrap = (r_cycle_time == c_last);
   assign w_next = w_wrap ? '0 : (r_cycle_time + c_one);

   // At the wrap edge the freshly mapped pulse must already govern the
   // output, otherwise the first clock of the frame would use the old width.
   assign w_frame_pulse = w_wrap ? w_pulse_new : r_pulse_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cycle_time <= c_last;
         r_servo_pwm  <= 1'b0;
         r_pulse_q    <= c_min_clks;
      end else if (enable) begin
         r_cycle_time <= w_next;
         r_servo_pwm  <= (w_next < w_frame_pulse);
         if (w_wrap) begin
            r_pulse_q <= w_pulse_new;
         end
      end else begin
         // Park at end-of-frame so re-enabling starts a clean frame.
         r_cycle_time <= c_last;
         r_servo_pwm  <= 1'b0;
      end
   end

   assign servo_pwm  = r_servo_pwm;
   assign cycle_time = r_cycle_time;
   assign n_clks     = c_n_clks;

endmodule
`default_nettype wire

// File: tb/tb_servo_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_servo_controller                                          |
// | Description : Self-checking bench for servo_controller. Two instances: a   |
// |               100 kHz-clock build (2000-clock frame, 100..200 clock pulse) |
// |               and a 1 kHz-clock build (20-clock frame, 1..2 clock pulse).  |
// |               Stimulus pushes the expected pulse width of every frame into |
// |               a queue; per-instance monitors measure each completed frame  |
// |               and compare it against the queue head.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_servo_controller;

   // Reference figures derived straight from the frequency/pulse definitions.
   localparam int MAIN_CLK = 100_000;
   localparam int MAIN_N   = MAIN_CLK / 50;
   localparam int MAIN_MIN = MAIN_CLK / 1000 * 1000 / 1000;   // 1000 us
   localparam int MAIN_MAX = MAIN_CLK / 1000 * 2000 / 1000;   // 2000 us
   localparam int SML_CLK  = 1000;
   localparam int SML_N    = SML_CLK / 50;
   localparam int SML_MIN  = 1;
   localparam int SML_MAX  = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        enable;
   logic [7:0]  duty_cycle;
   logic        servo_pwm;
   logic [31:0] n_clks;
   logic [31:0] cycle_time;

   logic        enable_s;
   logic [7:0]  duty_s;
   logic        servo_pwm_s;
   logic [31:0] n_clks_s;
   logic [31:0] cycle_time_s;

   int n_tests = 0;
   int n_fail  = 0;
   int main_checked  = 0;
   int small_checked = 0;
   bit mon_en   = 1'b0;
   bit mon_s_en = 1'b0;
   int exp_q[$];
   int exp_s_q[$];

   servo_controller #(
      .CLOCK_FREQ(MAIN_CLK), .PWM_FREQ(50), .MIN_PULSE_US(1000), .MAX_PULSE_US(2000), .WIDTH(32)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .duty_cycle(duty_cycle),
      .servo_pwm(servo_pwm), .n_clks(n_clks), .cycle_time(cycle_time)
   );

   servo_controller #(
      .CLOCK_FREQ(SML_CLK), .PWM_FREQ(50), .MIN_PULSE_US(1000), .MAX_PULSE_US(2000), .WIDTH(32)
   ) dut_s (
      .clock(clock), .reset(reset), .enable(enable_s), .duty_cycle(duty_s),
      .servo_pwm(servo_pwm_s), .n_clks(n_clks_s), .cycle_time(cycle_time_s)
   );

   initial forever #5 clock = ~clock;

   // Linear position-to-width rule, plain integer arithmetic.
   function automatic int pulse_of(input int d, input int mn, input int mx);
      return mn + (d * (mx - mn)) / 255;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic judge(input string name, input int exp, input int hi, input int len,
                        input int n, input bit contig);
      n_tests++;
      if (!(hi == exp && len == n && contig)) begin
         n_fail++;
         $display("FAIL %s: high=%0d len=%0d contiguous=%0d, required high=%0d len=%0d contiguous=1",
                  name, hi, len, contig, exp, n);
      end
   endtask

   // One frame of the large instance, entered and left at cycle position 0.
   // The duty for the following frame is applied mid-frame at position p.
   task automatic run_frame(input int p, input int d);
      repeat (p) @(negedge clock);
      duty_cycle = 8'(d);
      exp_q.push_back(pulse_of(d, MAIN_MIN, MAIN_MAX));
      repeat (MAIN_N - p) @(negedge clock);
   endtask

   // Frame monitor, large instance.
   initial begin : mon_main
      int hi, len, e;
      bit seen_low, contig, open;
      open = 1'b0; hi = 0; len = 0; seen_low = 1'b0; contig = 1'b1;
      forever begin
         @(negedge clock);
         if (!mon_en) begin
            if (open) begin
               open = 1'b0;
               if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
         end else begin
            if (cycle_time == 32'd0) begin
               if (open) begin
                  if (exp_q.size() == 0) begin
                     n_tests++; n_fail++;
                     $display("FAIL main_frame: unexpected frame, high=%0d len=%0d, required none", hi, len);
                  end else begin
                     e = exp_q.pop_front();
                     judge("main_frame", e, hi, len, MAIN_N, contig);
                     main_checked++;
                  end
               end
               open = 1'b1; hi = 0; len = 0; seen_low = 1'b0; contig = 1'b1;
            end
            if (open) begin
               len++;
               if (servo_pwm) begin
                  hi++;
                  if (seen_low) contig = 1'b0;
               end else begin
                  seen_low = 1'b1;
               end
            end
         end
      end
   end

   // Frame monitor, small instance.
   initial begin : mon_small
      int hi, len, e;
      bit seen_low, contig, open;
      open = 1'b0; hi = 0; len = 0; seen_low = 1'b0; contig = 1'b1;
      forever begin
         @(negedge clock);
         if (!mon_s_en) begin
            if (open) begin
               open = 1'b0;
               if (exp_s_q.size() > 0) void'(exp_s_q.pop_front());
            end
         end else begin
            if (cycle_time_s == 32'd0) begin
               if (open) begin
                  if (exp_s_q.size() == 0) begin
                     n_tests++; n_fail++;
                     $display("FAIL small_frame: unexpected frame, high=%0d len=%0d, required none", hi, len);
                  end else begin
                     e = exp_s_q.pop_front();
                     judge("small_frame", e, hi, len, SML_N, contig);
                     small_checked++;
                  end
               end
               open = 1'b1; hi = 0; len = 0; seen_low = 1'b0; contig = 1'b1;
            end
            if (open) begin
               len++;
               if (servo_pwm_s) begin
                  hi++;
                  if (seen_low) contig = 1'b0;
               end else begin
                  seen_low = 1'b1;
               end
            end
         end
      end
   end

   // Small-instance stimulus: random duty per frame, biased towards 255.
   initial begin : stim_small
      int p, d;
      enable_s = 1'b1;
      duty_s   = 8'd0;
      @(posedge reset);
      exp_s_q.push_back(pulse_of(0, SML_MIN, SML_MAX));
      mon_s_en = 1'b1;
      @(negedge clock);
      for (int f = 0; f < 30; f++) begin
         p = int'($urandom_range(1, SML_N - 2));
         d = ($urandom_range(0, 2) == 0) ? 255 : int'($urandom_range(0, 255));
         repeat (p) @(negedge clock);
         duty_s = 8'(d);
         exp_s_q.push_back(pulse_of(d, SML_MIN, SML_MAX));
         repeat (SML_N - p) @(negedge clock);
      end
      @(negedge clock);
      mon_s_en = 1'b0;
   end

   // Large-instance stimulus and directed checks.
   initial begin : stim_main
      int d;
      enable     = 1'b1;
      duty_cycle = 8'd0;
      repeat (3) @(negedge clock);
      check("reset_cycle_time",   cycle_time,   MAIN_N - 1);
      check("reset_pwm",          servo_pwm,    0);
      check("reset_n_clks",       n_clks,       MAIN_N);
      check("reset_cycle_time_s", cycle_time_s, SML_N - 1);
      check("reset_pwm_s",        servo_pwm_s,  0);
      check("reset_n_clks_s",     n_clks_s,     SML_N);

      exp_q.push_back(pulse_of(0, MAIN_MIN, MAIN_MAX));
      mon_en = 1'b1;
      reset  = 1'b1;
      @(negedge clock);
      check("release_cycle_time", cycle_time, 0);
      check("release_pwm",        servo_pwm,  1);

      run_frame(50, 255);                                  // mid-frame change 0 -> 255
      run_frame(int'($urandom_range(1, MAIN_N - 2)), 128);
      run_frame(int'($urandom_range(1, MAIN_N - 2)), 255);
      for (int f = 0; f < 4; f++)
         run_frame(int'($urandom_range(1, MAIN_N - 2)), int'($urandom_range(0, 255)));

      // Enable dropped inside the pulse, held, then restored.
      repeat (30) @(negedge clock);
      enable = 1'b0;
      mon_en = 1'b0;
      @(negedge clock);
      check("disable_pwm",        servo_pwm,  0);
      check("disable_cycle_time", cycle_time, MAIN_N - 1);
      repeat (499) @(negedge clock);
      check("hold_pwm",           servo_pwm,  0);
      check("hold_cycle_time",    cycle_time, MAIN_N - 1);
      d = int'($urandom_range(0, 255));
      duty_cycle = 8'(d);
      exp_q.push_back(pulse_of(d, MAIN_MIN, MAIN_MAX));
      enable = 1'b1;
      mon_en = 1'b1;
      @(negedge clock);
      check("reenable_cycle_time", cycle_time, 0);
      check("reenable_pwm",        servo_pwm,  1);
      run_frame(int'($urandom_range(1, MAIN_N - 2)), int'($urandom_range(0, 255)));

      // Asynchronous reset between edges, inside the pulse.
      repeat (40) @(negedge clock);
      #2;
      reset  = 1'b0;
      mon_en = 1'b0;
      #1;
      check("async_reset_pwm",        servo_pwm,  0);
      check("async_reset_cycle_time", cycle_time, MAIN_N - 1);
      @(negedge clock);
      d = int'($urandom_range(0, 255));
      duty_cycle = 8'(d);
      exp_q.push_back(pulse_of(d, MAIN_MIN, MAIN_MAX));
      mon_en = 1'b1;
      reset  = 1'b1;
      @(negedge clock);
      check("rerelease_cycle_time", cycle_time, 0);
      check("rerelease_pwm",        servo_pwm,  1);
      run_frame(int'($urandom_range(1, MAIN_N - 2)), int'($urandom_range(0, 255)));

      @(negedge clock);
      mon_en = 1'b0;
      repeat (2) @(negedge clock);
      check("main_frames_checked",  main_checked,    9);
      check("main_queue_drained",   exp_q.size(),    0);
      check("small_frames_checked", small_checked,   30);
      check("small_queue_drained",  exp_s_q.size(),  0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
